// File: rtl/spi_txn_scheduler.sv
// Two-port round-robin transfer scheduler in front of the spi_top core: latches the winner's
// byte and clock mode, strobes the core, watches master_state, and returns the received byte.
module spi_txn_scheduler #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned START_WAIT  = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    input  logic [1:0] mode0,
    input  logic [1:0] mode1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rx_data,
    output logic       err,
    output logic       busy,
    output logic       cpol,
    output logic       cpha,
    output logic [7:0] master_datain,
    output logic       write_en,
    output logic       read_en,
    input  logic [2:0] master_state,
    input  logic [7:0] master_miso_data
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_COMPLETE = 3'd4;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] START_LAST = 16'(START_WAIT - 1);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_tmo;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err;
    logic        r_busy;
    logic        r_cpol;
    logic        r_cpha;
    logic        r_strobe;
    logic [7:0]  r_rx_data;
    logic [7:0]  r_datain;

    logic [2:0]  w_next;
    logic        w_grant_idx;
    logic        w_tmo_set;
    logic        w_core_idle;
    logic        w_req_ok;
    logic [7:0]  w_tx_sel;
    logic [1:0]  w_mode_sel;

    // Arbitration and next-state decode.
    always_comb begin
        w_next      = r_state;
        w_tmo_set   = 1'b0;
        w_core_idle = (master_state == 3'd0);
        // A requester still holding req in its own ack cycle is only re-arbitrated afterwards.
        w_req_ok    = (req0 | req1) & ~r_ack0 & ~r_ack1;

        if (req0 && req1) begin
            w_grant_idx = ~r_last_grant;
        end else if (req1) begin
            w_grant_idx = 1'b1;
        end else begin
            w_grant_idx = 1'b0;
        end

        if (w_grant_idx) begin
            w_tx_sel   = tx1;
            w_mode_sel = mode1;
        end else begin
            w_tx_sel   = tx0;
            w_mode_sel = mode0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_req_ok) begin
                    w_next = S_SETUP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_next = S_START;
                end else begin
                    w_next = S_SETUP;
                end
            end
            S_START: begin
                if (!w_core_idle) begin
                    w_next = S_WAIT;
                end else if (r_cnt == START_LAST) begin
                    w_next    = S_COMPLETE;
                    w_tmo_set = 1'b1;
                end else begin
                    w_next = S_START;
                end
            end
            S_WAIT: begin
                if (w_core_idle) begin
                    w_next = S_COMPLETE;
                end else if (r_cnt == TMO_LAST) begin
                    w_next    = S_COMPLETE;
                    w_tmo_set = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_COMPLETE: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // State, wait counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'd0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_tmo        <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_strobe     <= 1'b0;
            r_rx_data    <= 8'h00;
            r_datain     <= 8'h00;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != S_IDLE);
            r_strobe <= (w_next == S_START);
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err    <= 1'b0;

            if (w_next != r_state) begin
                r_cnt <= 16'd0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= r_cnt;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_next == S_SETUP) begin
                        r_grant  <= w_grant_idx;
                        r_datain <= w_tx_sel;
                        r_cpol   <= w_mode_sel[1];
                        r_cpha   <= w_mode_sel[0];
                        r_tmo    <= 1'b0;
                    end else begin
                        r_grant  <= r_grant;
                    end
                end
                S_START, S_WAIT: begin
                    if (w_tmo_set) begin
                        r_tmo <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo;
                    end
                end
                S_COMPLETE: begin
                    r_ack0       <= ~r_grant;
                    r_ack1       <= r_grant;
                    r_err        <= r_tmo;
                    r_rx_data    <= r_tmo ? 8'h00 : master_miso_data;
                    r_last_grant <= r_grant;
                end
                default: begin
                    r_tmo <= r_tmo;
                end
            endcase
        end
    end

    assign ack0          = r_ack0;
    assign ack1          = r_ack1;
    assign err           = r_err;
    assign busy          = r_busy;
    assign cpol          = r_cpol;
    assign cpha          = r_cpha;
    assign rx_data       = r_rx_data;
    assign master_datain = r_datain;
    assign write_en      = r_strobe;
    assign read_en       = r_strobe;
endmodule
